// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter and fetch sequencer with branch-if-equal, halt and retire counting
module pc_sequencer #(
  parameter int PC_W     = 10,
  parameter int END_ADDR = 1023,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  input  logic             branch_en,
  input  logic [7:0]       alu_result,
  input  logic [PC_W-1:0]  branch_target,
  input  logic             halt_req,
  output logic [PC_W-1:0]  pc,
  output logic             fetch_valid,
  output logic             branch_taken,
  output logic             done,
  output logic [CNT_W-1:0] instr_count
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;
  localparam logic [PC_W-1:0] LAST = PC_W'(END_ADDR);
  logic [1:0]       r_state;
  logic [PC_W-1:0]  r_pc;
  logic             r_taken;
  logic [CNT_W-1:0] r_count;
  logic             w_take;
  logic             w_last;
  logic [CNT_W-1:0] w_count_inc;
  // a zero ALU result means the compared operands were equal
  assign w_take      = branch_en && (alu_result == 8'h00);
  // a pc at or beyond the last address cannot advance sequentially (run-off)
  assign w_last      = r_pc >= LAST;
  assign w_count_inc = (&r_count) ? r_count : r_count + CNT_W'(1);
  // state, pc, branch pulse and retire counter; every unstalled RUN cycle retires one instruction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_taken <= 1'b0;
      r_count <= '0;
    end else begin
      r_taken <= 1'b0;
      if (r_state == S_RUN) begin
        if (!stall) begin
          r_count <= w_count_inc;
          if (halt_req) r_state <= S_HALT;
          else if (w_take) begin
            r_pc    <= branch_target;
            r_taken <= 1'b1;
          end else if (!w_last) r_pc <= r_pc + PC_W'(1);
          else r_state <= S_HALT;
        end
      end else if (start) begin
        r_state <= S_RUN;
        r_pc    <= '0;
        r_count <= '0;
      end else if (r_state != S_HALT) r_state <= S_IDLE;
    end
  end
  assign pc           = r_pc;
  assign fetch_valid  = r_state == S_RUN;
  assign done         = r_state == S_HALT;
  assign branch_taken = r_taken;
  assign instr_count  = r_count;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench for a default build and a small END_ADDR=15 / CNT_W=4 build
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic reset, start, stall, branch_en, halt_req;
  logic [7:0] alu_result;
  logic [9:0] branch_target;
  logic [9:0] pc_a;
  logic fv_a, bt_a, dn_a;
  logic [15:0] cnt_a;
  logic [4:0] pc_b;
  logic fv_b, bt_b, dn_b;
  logic [3:0] cnt_b;
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  typedef struct {
    int cyc;
    bit inst;
    logic [9:0] pc;
    logic fv;
    logic bt;
    logic dn;
    logic [15:0] cnt;
    string nm;
  } exp_t;
  exp_t q[$];

  pc_sequencer dut_a (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .branch_en(branch_en),
    .alu_result(alu_result), .branch_target(branch_target), .halt_req(halt_req),
    .pc(pc_a), .fetch_valid(fv_a), .branch_taken(bt_a), .done(dn_a), .instr_count(cnt_a)
  );

  pc_sequencer #(.PC_W(5), .END_ADDR(15), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .branch_en(branch_en),
    .alu_result(alu_result), .branch_target(branch_target[4:0]), .halt_req(halt_req),
    .pc(pc_b), .fetch_valid(fv_b), .branch_taken(bt_b), .done(dn_b), .instr_count(cnt_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic [9:0] a_pc;
      logic [15:0] a_cnt;
      logic a_fv, a_bt, a_dn;
      e = q.pop_front();
      a_pc  = e.inst ? {5'b0, pc_b} : pc_a;
      a_cnt = e.inst ? {12'b0, cnt_b} : cnt_a;
      a_fv  = e.inst ? fv_b : fv_a;
      a_bt  = e.inst ? bt_b : bt_a;
      a_dn  = e.inst ? dn_b : dn_a;
      n_cmp++;
      if ({a_pc, a_fv, a_bt, a_dn, a_cnt} !== {e.pc, e.fv, e.bt, e.dn, e.cnt}) begin
        n_bad++;
        $display("FAIL %s: got pc=%0d fv=%b bt=%b done=%b cnt=%0d, expected pc=%0d fv=%b bt=%b done=%b cnt=%0d",
                 e.nm, a_pc, a_fv, a_bt, a_dn, a_cnt, e.pc, e.fv, e.bt, e.dn, e.cnt);
      end
    end
  end

  task automatic step(input string nm, input logic st, input logic sl, input logic be,
                      input logic [7:0] alu, input logic [9:0] tgt, input logic hr,
                      input bit inst, input logic [9:0] epc, input logic efv,
                      input logic ebt, input logic edn, input logic [15:0] ecnt);
    start = st; stall = sl; branch_en = be; alu_result = alu; branch_target = tgt; halt_req = hr;
    q.push_back('{cyc + 1, inst, epc, efv, ebt, edn, ecnt, nm});
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; start = 0; stall = 0; branch_en = 0; alu_result = 0; branch_target = 0; halt_req = 0;
    @(negedge clk);
    step("rst_hold", 1, 0, 1, 0, 40, 1, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    step("idle_ignore", 0, 0, 1, 0, 40, 1, 0, 0, 0, 0, 0, 0);
    step("start", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    step("seq1", 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1);
    step("seq2", 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 2);
    step("seq3", 0, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0, 3);
    step("halt", 0, 0, 0, 0, 0, 1, 0, 3, 0, 0, 1, 4);
    step("halt_hold", 0, 0, 1, 0, 40, 0, 0, 3, 0, 0, 1, 4);
    step("restart", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    step("seq_b1", 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1);
    step("seq_b2", 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 2);
    step("br_taken", 0, 0, 1, 8'h00, 40, 0, 0, 40, 1, 1, 0, 3);
    step("br_pulse_end", 0, 0, 0, 0, 0, 0, 0, 41, 1, 0, 0, 4);
    step("br_back", 0, 0, 1, 8'h00, 2, 0, 0, 2, 1, 1, 0, 5);
    step("br_not_taken", 0, 0, 1, 8'h01, 40, 0, 0, 3, 1, 0, 0, 6);
    step("br_to7", 0, 0, 1, 8'h00, 7, 0, 0, 7, 1, 1, 0, 7);
    for (int i = 0; i < 3; i++) step("stall_prio", 0, 1, 1, 8'h00, 40, 1, 0, 7, 1, 0, 0, 7);
    step("halt_wins", 0, 0, 1, 8'h00, 40, 1, 0, 7, 0, 0, 1, 8);
    step("restart2", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 1; i <= 5; i++) step("seq_to5", 0, 0, 0, 0, 0, 0, 0, 10'(i), 1, 0, 0, 16'(i));
    start = 0; stall = 0; branch_en = 0; halt_req = 0;
    q.push_back('{cyc + 1, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 16'd0, "async_rst"});
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (pc_a !== 10'd0) begin n_bad++; $display("FAIL async_rst_pc: got pc=%0d", pc_a); end
    n_cmp++;
    if (fv_a !== 1'b0) begin n_bad++; $display("FAIL async_rst_fv: got fv=%b", fv_a); end
    n_cmp++;
    if (dn_a !== 1'b0) begin n_bad++; $display("FAIL async_rst_done: got done=%b", dn_a); end
    n_cmp++;
    if (cnt_a !== 16'd0) begin n_bad++; $display("FAIL async_rst_cnt: got cnt=%0d", cnt_a); end
    @(negedge clk);
    reset = 1'b0;
    step("start_after_rst", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    step("start_in_run", 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1);
    step("start_in_run2", 1, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 2);
    start = 0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    step("b_start", 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    step("b_br14", 0, 0, 1, 8'h00, 14, 0, 1, 14, 1, 1, 0, 1);
    step("b_seq15", 0, 0, 0, 0, 0, 0, 1, 15, 1, 0, 0, 2);
    step("b_runoff", 0, 0, 0, 0, 0, 0, 1, 15, 0, 0, 1, 3);
    step("b_restart", 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    step("b_br20", 0, 0, 1, 8'h00, 20, 0, 1, 20, 1, 1, 0, 1);
    step("b_beyond_end", 0, 0, 0, 0, 0, 0, 1, 20, 0, 0, 1, 2);
    step("b_restart2", 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    for (int k = 1; k <= 20; k++)
      step("b_sat", (k == 10), 0, 1, 8'h00, 0, 0, 1, 0, 1, 1, 0, (k > 15) ? 16'd15 : 16'(k));
    step("b_sat_stall", 0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 15);
    repeat (2) @(negedge clk);
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL %s: expectation never compared, expected pc=%0d", e.nm, e.pc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter and fetch sequencer for the 8-bit custom CPU.
- Sits upstream of the ALU and instruction memory: it drives the fetch address and retires one instruction per unstalled cycle.
- Consumes the ALU's 8-bit result to resolve branch-if-equal, where a result of 0x00 means the operands were equal.
- Provides start/done handshaking with the testbench/top level and a retired-instruction counter.

Parameters:
- PC_W, 10, width of program counter / instruction memory address.
- END_ADDR, 1023, last valid instruction address; sequential increment past it terminates the program.
- CNT_W, 16, width of retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  level/pulse request to begin execution from address 0; honoured only in IDLE or HALT.
- stall  input  1  freeze: current instruction is not retired this cycle.
- branch_en  input  1  decoder flag: the current instruction is branch-if-equal.
- alu_result  input  8  ALU output for the current instruction.
- branch_target  input  PC_W  absolute target from the branch lookup table.
- halt_req  input  1  decoder flag: the current instruction is the halt opcode.
- pc  output  PC_W  current fetch address (registered).
- fetch_valid  output  1  high while in RUN; pc addresses a live instruction.
- branch_taken  output  1  registered one-cycle pulse: the previous retire redirected pc.
- done  output  1  high while in HALT.
- instr_count  output  CNT_W  instructions retired since last start.

Behaviour:
Reset and state machine:
- Reset (asynchronous assert, release on clock edge) sets:
  - state IDLE;
  - pc=0, fetch_valid=0, branch_taken=0, done=0, instr_count=0.
- Reset mid-RUN aborts immediately to these values; no partial retire.
- States: IDLE, RUN, HALT.
- fetch_valid = (state==RUN); done = (state==HALT). Both are registered via state and carry no combinational input paths.

IDLE:
- start=1 -> RUN next edge; pc=0, instr_count=0.
- All other inputs are ignored.

RUN, stall=1:
- Hold pc, instr_count and state.
- branch_taken=0.
- halt_req and branch_en are ignored (stall has top priority).

RUN, stall=0 (retire), evaluated in this priority order:
1. halt_req=1 -> HALT.
   - pc holds (points at the halt instruction).
   - instr_count increments (the halt counts as retired).
   - branch_en is ignored.
2. branch_en=1 and alu_result==8'h00 -> pc=branch_target, branch_taken=1.
3. branch_en=1 and alu_result!=8'h00 -> fall through to the sequential rule; branch_taken=0.
4. Sequential, pc<END_ADDR -> pc=pc+1.
5. Sequential, pc==END_ADDR -> HALT (run-off).
   - pc holds at END_ADDR.
   - instr_count increments.

Every retire increments instr_count. The counter saturates at all-ones and does not wrap.

Branch target rules:
- A taken branch to any address, including END_ADDR or the current pc (a self-loop), is legal.
- A branch_target greater than END_ADDR is loaded as given; the next sequential increment from it behaves per the pc<END_ADDR / pc==END_ADDR rules. Because such a pc is neither less than nor equal to END_ADDR, it is treated as run-off and goes to HALT on the next sequential retire.

HALT:
- Outputs hold.
- start=1 -> RUN next edge with pc=0, instr_count=0, done=0.

Other timing rules:
- start while in RUN is ignored.
- Latency: pc changes on the same edge the instruction retires; instruction memory sees the new address in the following cycle.
- branch_taken is high for exactly the cycle after a taken retire.

Test Plan:
1. Reset mid-run:
   - Stimulus: assert reset asynchronously between edges while pc=5.
   - Response: pc=0, fetch_valid=0, done=0, instr_count=0 before the next edge; start then runs from 0.
2. Sequential run with halt:
   - Stimulus: start, no branches, halt_req=1 when pc=3.
   - Response: pc sequence 0,1,2,3,3; done=1; instr_count=4; fetch_valid falls with done rising.
3. Branch taken vs not taken:
   - Stimulus: at pc=2 with branch_en=1, branch_target=40, alu_result=8'h00.
   - Response: pc=40 and branch_taken=1 for one cycle.
   - Stimulus: repeat with alu_result=8'h01.
   - Response: pc=3, branch_taken=0.
4. Stall priority:
   - Stimulus: at pc=7 hold stall=1 for 3 cycles with halt_req=1 and branch_en=1, alu_result=0.
   - Response: pc stays 7, count unchanged, branch_taken=0, no HALT.
   - Stimulus: drop stall.
   - Response: HALT with count+1.
   - Stimulus: same cycle carrying both halt_req and a taken branch.
   - Response: halt wins.
5. Run-off:
   - Stimulus: END_ADDR=15 build, branch to 14, no further branches.
   - Response: pc 14, 15, 15; done=1.
6. Restart and counter saturation:
   - Stimulus: start from HALT.
   - Response: pc=0, count=0, done=0.
   - Stimulus: CNT_W=4 build with a self-loop branch for 20 retires.
   - Response: instr_count=4'hF, no wrap; start asserted during RUN has no effect.
